// File: rtl/result_writeback_queue_if.sv
// Result/writeback bundle between the arithmetic unit, the writeback queue and the
// register-file write ports.
interface result_writeback_queue_if #(
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned NUM_WB = 1,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DST_W  = 5,
   parameter int unsigned DATA_W = 32
);
   typedef struct packed {
      logic              valid;
      logic [DST_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } vuop_result_t;

   vuop_result_t           res_in [NUM_IN];
   logic                   in_ready;
   logic                   flush_in;
   logic                   wb_en [NUM_WB];
   logic [DST_W-1:0]       wb_dst [NUM_WB];
   logic [DATA_W-1:0]      wb_data [NUM_WB];
   logic [$clog2(DEPTH):0] count;
   logic                   overflow_err;

   modport master (
      output res_in, flush_in,
      input  in_ready, wb_en, wb_dst, wb_data, count, overflow_err
   );

   modport slave (
      input  res_in, flush_in,
      output in_ready, wb_en, wb_dst, wb_data, count, overflow_err
   );
endinterface

// File: rtl/result_writeback_queue.sv
// Compacts valid result lanes into an in-order circular buffer and drains it onto
// NUM_WB register-file write ports, with back-pressure, flush and sticky overflow.
module result_writeback_queue #(
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned NUM_WB = 1,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DST_W  = 5,
   parameter int unsigned DATA_W = 32
) (
   input logic                   clock,
   input logic                   reset,
   result_writeback_queue_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - NUM_IN);
   localparam logic [CNT_W-1:0] WB_MAX    = CNT_W'(NUM_WB);

   logic [DST_W-1:0]  mem_dst_q  [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  push_n, pop_n;
   logic              any_valid, push_ok;
   logic [PTR_W-1:0]  lane_addr [NUM_IN];

   // Each valid lane lands just after the valid lanes below it, so invalid lanes leave no holes.
   always_comb begin
      push_n    = '0;
      any_valid = 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         lane_addr[i] = wr_ptr_q + push_n[PTR_W-1:0];
         if (bus.res_in[i].valid) begin
            push_n    = push_n + 1'b1;
            any_valid = 1'b1;
         end
      end
   end

   assign bus.in_ready     = (count_q <= READY_MAX);
   assign push_ok          = bus.in_ready && !bus.flush_in;
   assign pop_n            = bus.flush_in ? '0 : ((count_q > WB_MAX) ? WB_MAX : count_q);
   assign bus.count        = count_q;
   assign bus.overflow_err = overflow_q;

   always_comb begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
         bus.wb_en[k]   = (count_q > CNT_W'(k)) && !bus.flush_in;
         bus.wb_dst[k]  = mem_dst_q[rd_ptr_q + PTR_W'(k)];
         bus.wb_data[k] = mem_data_q[rd_ptr_q + PTR_W'(k)];
      end
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q + pop_n[PTR_W-1:0];
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q - pop_n;
      overflow_d = overflow_q;
      if (bus.flush_in) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (push_ok) begin
         wr_ptr_d = wr_ptr_q + push_n[PTR_W-1:0];
         count_d  = count_q + push_n - pop_n;
      end else if (any_valid) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: entries are only observable below count.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (bus.res_in[i].valid) begin
               mem_dst_q[lane_addr[i]]  <= bus.res_in[i].dst;
               mem_data_q[lane_addr[i]] <= bus.res_in[i].data;
            end
         end
      end
   end
endmodule

// File: tb/tb_result_writeback_queue.sv
// Self-checking bench for result_writeback_queue: directed scenarios plus randomized
// streams compared against a queue-based reference model.
module tb_result_writeback_queue;
   localparam int unsigned NUM_IN = 2;
   localparam int unsigned NUM_WB = 1;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned DST_W  = 5;
   localparam int unsigned DATA_W = 32;

   typedef struct packed {
      logic [DST_W-1:0]  dst;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   ent_t mq[$];
   bit   m_ovf = 1'b0;

   result_writeback_queue_if #(
      .NUM_IN(NUM_IN), .NUM_WB(NUM_WB), .DEPTH(DEPTH), .DST_W(DST_W), .DATA_W(DATA_W)
   ) bus ();

   result_writeback_queue #(
      .NUM_IN(NUM_IN), .NUM_WB(NUM_WB), .DEPTH(DEPTH), .DST_W(DST_W), .DATA_W(DATA_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic set_lane(input int l, input bit v, input logic [DST_W-1:0] d,
                           input logic [DATA_W-1:0] x);
      bus.res_in[l].valid = v;
      bus.res_in[l].dst   = d;
      bus.res_in[l].data  = x;
   endtask

   task automatic idle();
      set_lane(0, 1'b0, '0, '0);
      set_lane(1, 1'b0, '0, '0);
      bus.flush_in = 1'b0;
   endtask

   // Reference: flush empties everything; otherwise the head pops up to NUM_WB entries and
   // valid lanes append in lane order if the occupancy before this cycle left room for a burst.
   task automatic tick();
      bit room;
      int n;
      room = (int'(DEPTH) - mq.size()) >= int'(NUM_IN);
      if (bus.flush_in) begin
         mq.delete();
      end else begin
         n = (mq.size() < int'(NUM_WB)) ? mq.size() : int'(NUM_WB);
         repeat (n) void'(mq.pop_front());
         for (int l = 0; l < int'(NUM_IN); l++) begin
            if (bus.res_in[l].valid) begin
               if (room) mq.push_back({bus.res_in[l].dst, bus.res_in[l].data});
               else m_ovf = 1'b1;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic run_stream(input int cycles, input int pv, input int pf);
      bit exp_en;
      bit exp_rdy;
      for (int c = 0; c < cycles; c++) begin
         for (int l = 0; l < int'(NUM_IN); l++)
            set_lane(l, $urandom_range(99) < pv, DST_W'($urandom), $urandom);
         bus.flush_in = $urandom_range(99) < pf;
         @(negedge clock);
         exp_en  = (mq.size() > 0) && !bus.flush_in;
         exp_rdy = (int'(DEPTH) - mq.size()) >= int'(NUM_IN);
         checks += 4;
         if (bus.count !== 4'(mq.size())) begin
            errors++;
            $display("FAIL stream_count: got %0d expected %0d", bus.count, mq.size());
         end
         if (bus.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL stream_in_ready: got %0b expected %0b", bus.in_ready, exp_rdy);
         end
         if (bus.overflow_err !== m_ovf) begin
            errors++;
            $display("FAIL stream_overflow: got %0b expected %0b", bus.overflow_err, m_ovf);
         end
         if (bus.wb_en[0] !== exp_en) begin
            errors++;
            $display("FAIL stream_wb_en: got %0b expected %0b", bus.wb_en[0], exp_en);
         end
         if (exp_en) begin
            checks++;
            if (bus.wb_dst[0] !== mq[0].dst || bus.wb_data[0] !== mq[0].data) begin
               errors++;
               $display("FAIL stream_wb_entry: got %0d/%h expected %0d/%h",
                        bus.wb_dst[0], bus.wb_data[0], mq[0].dst, mq[0].data);
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      #12;
      checks += 4;
      if (bus.count !== 4'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", bus.count);
      end
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
      end
      if (bus.wb_en[0] !== 1'b0) begin
         errors++; $display("FAIL reset_wb_en: got %0b expected 0", bus.wb_en[0]);
      end
      if (bus.overflow_err !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %0b expected 0", bus.overflow_err);
      end
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_single();
      set_lane(0, 1'b0, '0, '0);
      set_lane(1, 1'b1, 5'd5, 32'hA5);
      @(negedge clock);
      checks++;
      if (bus.wb_en[0] !== 1'b0) begin
         errors++; $display("FAIL single_c0_wb_en: got %0b expected 0", bus.wb_en[0]);
      end
      tick();
      idle();
      @(negedge clock);
      checks += 3;
      if (bus.wb_en[0] !== 1'b1) begin
         errors++; $display("FAIL single_c1_wb_en: got %0b expected 1", bus.wb_en[0]);
      end
      if (bus.wb_dst[0] !== 5'd5) begin
         errors++; $display("FAIL single_c1_dst: got %0d expected 5", bus.wb_dst[0]);
      end
      if (bus.wb_data[0] !== 32'hA5) begin
         errors++; $display("FAIL single_c1_data: got %h expected a5", bus.wb_data[0]);
      end
      tick();
      @(negedge clock);
      checks += 2;
      if (bus.count !== 4'd0) begin
         errors++; $display("FAIL single_c2_count: got %0d expected 0", bus.count);
      end
      if (bus.wb_en[0] !== 1'b0) begin
         errors++; $display("FAIL single_c2_wb_en: got %0b expected 0", bus.wb_en[0]);
      end
      tick();
   endtask

   task automatic test_order();
      logic [DST_W-1:0] exp_d;
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) begin
            set_lane(0, 1'b1, 5'd1, 32'h11);
            set_lane(1, 1'b1, 5'd2, 32'h22);
         end else if (c == 1) begin
            set_lane(1, 1'b1, 5'd3, 32'h33);
         end
         @(negedge clock);
         if (c >= 1 && c <= 3) begin
            exp_d = DST_W'(c);
            checks += 2;
            if (bus.wb_en[0] !== 1'b1) begin
               errors++; $display("FAIL order_wb_en_c%0d: got %0b expected 1", c, bus.wb_en[0]);
            end
            if (bus.wb_dst[0] !== exp_d) begin
               errors++;
               $display("FAIL order_dst_c%0d: got %0d expected %0d", c, bus.wb_dst[0], exp_d);
            end
         end
         if (c == 4) begin
            checks++;
            if (bus.count !== 4'd0) begin
               errors++; $display("FAIL order_final_count: got %0d expected 0", bus.count);
            end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_push_pop();
      int next_exp = 10;
      for (int c = 0; c < 18; c++) begin
         idle();
         if (c < 5) begin
            set_lane(0, 1'b1, DST_W'(10 + 2 * c), 32'(32'h100 + 10 + 2 * c));
            set_lane(1, 1'b1, DST_W'(11 + 2 * c), 32'(32'h100 + 11 + 2 * c));
         end else if (c == 5) begin
            set_lane(1, 1'b1, 5'd20, 32'h114);
         end
         @(negedge clock);
         if (c == 5 || c == 6) begin
            checks += 2;
            if (bus.count !== 4'd6) begin
               errors++; $display("FAIL pushpop_count_c%0d: got %0d expected 6", c, bus.count);
            end
            if (bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL pushpop_in_ready_c%0d: got %0b expected 1", c, bus.in_ready);
            end
         end
         if (bus.wb_en[0] === 1'b1) begin
            checks++;
            if (bus.wb_dst[0] !== DST_W'(next_exp) || bus.wb_data[0] !== 32'(32'h100 + next_exp))
            begin
               errors++;
               $display("FAIL pushpop_order: got %0d/%h expected %0d/%h", bus.wb_dst[0],
                        bus.wb_data[0], next_exp, 32'h100 + next_exp);
            end
            next_exp++;
         end
         tick();
      end
      checks++;
      if (next_exp != 21) begin
         errors++; $display("FAIL pushpop_total: got %0d writebacks expected 11", next_exp - 10);
      end
   endtask

   task automatic test_fill_backpressure();
      run_stream(16, 100, 0);
      @(negedge clock);
      checks++;
      if (bus.overflow_err !== 1'b1) begin
         errors++; $display("FAIL fill_overflow: got %0b expected 1", bus.overflow_err);
      end
      tick();
      run_stream(10, 0, 0);
   endtask

   task automatic test_flush();
      for (int c = 0; c < 4; c++) begin
         set_lane(0, 1'b1, DST_W'($urandom), $urandom);
         set_lane(1, 1'b1, DST_W'($urandom), $urandom);
         tick();
      end
      bus.flush_in = 1'b1;
      @(negedge clock);
      checks += 2;
      if (bus.count !== 4'd5) begin
         errors++; $display("FAIL flush_pre_count: got %0d expected 5", bus.count);
      end
      if (bus.wb_en[0] !== 1'b0) begin
         errors++; $display("FAIL flush_wb_en: got %0b expected 0", bus.wb_en[0]);
      end
      tick();
      idle();
      @(negedge clock);
      checks += 3;
      if (bus.count !== 4'd0) begin
         errors++; $display("FAIL flush_post_count: got %0d expected 0", bus.count);
      end
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_post_in_ready: got %0b expected 1", bus.in_ready);
      end
      if (bus.overflow_err !== m_ovf) begin
         errors++;
         $display("FAIL flush_overflow_kept: got %0b expected %0b", bus.overflow_err, m_ovf);
      end
      tick();
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 3; c++) begin
         set_lane(0, 1'b1, DST_W'($urandom), $urandom);
         set_lane(1, 1'b1, DST_W'($urandom), $urandom);
         tick();
      end
      idle();
      #1;
      checks++;
      if (bus.count !== 4'd4) begin
         errors++; $display("FAIL areset_pre_count: got %0d expected 4", bus.count);
      end
      #1 reset = 1'b0;
      #1;
      checks += 4;
      if (bus.count !== 4'd0) begin
         errors++; $display("FAIL areset_count: got %0d expected 0", bus.count);
      end
      if (bus.wb_en[0] !== 1'b0) begin
         errors++; $display("FAIL areset_wb_en: got %0b expected 0", bus.wb_en[0]);
      end
      if (bus.overflow_err !== 1'b0) begin
         errors++; $display("FAIL areset_overflow: got %0b expected 0", bus.overflow_err);
      end
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL areset_in_ready: got %0b expected 1", bus.in_ready);
      end
      mq.delete();
      m_ovf = 1'b0;
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      test_single();
   endtask

   task automatic test_random();
      run_stream(400, 50, 3);
      run_stream(12, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_push_pop();
      test_fill_backpressure();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/result_writeback_queue.md
# result_writeback_queue

Receives the per-lane results produced by the arithmetic unit. It compacts the valid lanes into an in-order circular buffer, then drains that buffer onto a narrower set of register-file write ports. It sits between the arithmetic unit's registered result outputs and the vector register-file write ports. It applies back-pressure to issue, and shares the arithmetic unit's pipeline flush.

## Interface
Parameters:
- NUM_IN, default NUM_OF_ARI_ISSUE (2): number of result lanes accepted per cycle.
- NUM_WB, default 1: number of register-file write ports drained per cycle; 1 ≤ NUM_WB ≤ NUM_IN.
- DEPTH, default 8: number of buffer entries; must be a power of two and ≥ 2·NUM_IN.

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-low reset (asserted at 0).
- res_in[NUM_IN], in, vuop_result_t: per-lane results. Only the fields `valid`, `dst` and `data` are used.
- in_ready, out, 1: at least NUM_IN entries are free; issue stalls while it is 0.
- flush_in, in, 1: synchronous pipeline flush.
- wb_en[NUM_WB], out, 1 each: write enable of register-file port k.
- wb_dst[NUM_WB], out, vuop_result_t.dst width: destination register for port k.
- wb_data[NUM_WB], out, vuop_result_t.data width: write data for port k.
- count, out, $clog2(DEPTH)+1: current number of occupied entries.
- overflow_err, out, 1: sticky flag; a valid result arrived while in_ready was 0.

## Operation
- Storage is DEPTH entries of {dst, data} held in registers.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH with no special case.
  - count is a separate register.
- Push:
  - A push is accepted when in_ready=1 and flush_in=0.
  - Each valid lane is written at wr_ptr + (number of valid lanes with a lower index). This preserves lane order with lane 0 oldest, and leaves no holes for invalid lanes.
  - wr_ptr advances by push_n, the popcount of the valid lanes.
- Drain:
  - For k < NUM_WB: wb_en[k] = (count > k) && !flush_in.
  - wb_dst[k] and wb_data[k] come from the entry at rd_ptr + k.
  - The register file always accepts, so pop_n = min(count, NUM_WB) when flush_in=0.
  - rd_ptr advances by pop_n.
- Count update:
  - count_next = count + push_n − pop_n.
  - Push and pop in the same cycle are both honoured.
- Ready:
  - in_ready = (DEPTH − count) ≥ NUM_IN, decoded from the count register only.
  - It does not depend on the same-cycle pop.
- Overflow:
  - If in_ready=0 and any res_in valid=1 while flush_in=0, the results are dropped.
  - overflow_err is set to 1 and stays at 1 until reset. flush_in does not clear it.
- Flush:
  - rd_ptr, wr_ptr and count are cleared to 0. Storage contents are don't-care.
  - Flush takes priority over a simultaneous push and a simultaneous pop; nothing is written to the register file that cycle.
- Reset (async, low):
  - rd_ptr, wr_ptr, count and overflow_err are cleared to 0, so in_ready=1 and all wb_en=0.
  - Assertion in the middle of a drain aborts the drain immediately; no partial state survives.

## Timing
- Input-to-writeback latency is 1 cycle.
  - A result presented in cycle N is captured at the edge ending N.
  - If the buffer is empty, it appears on wb_en/wb_dst/wb_data in cycle N+1.
- wb_* are decoded combinationally from registers and flush_in. The only combinational input paths are flush_in → wb_en and res_in → next-state logic.
- in_ready is a registered-state decode. A drop in count is reflected in in_ready one cycle later.
- Throughput:
  - Sustained NUM_WB results/cycle out.
  - Bursts of NUM_IN/cycle are absorbed until count exceeds DEPTH − NUM_IN.
- Output values after reset release: in_ready=1, wb_en=0, count=0, overflow_err=0.

## Test plan
- Single result: lane 1 valid with dst=5, data=0xA5 in cycle 0, then idle.
  - Cycle 1: wb_en[0]=1, wb_dst[0]=5, wb_data[0]=0xA5.
  - Cycle 2: count=0.
- Ordering and compaction: NUM_IN=2, NUM_WB=1.
  - Cycle 0: lanes {0:dst1, 1:dst2}. Cycle 1: lane 1 only, dst3.
  - Writeback order is dst1, dst2, dst3 in cycles 1–3.
- Fill and back-pressure: DEPTH=8, both lanes valid every cycle.
  - in_ready drops to 0 once count reaches 7.
  - A further valid push sets overflow_err=1. Accepted entries drain intact.
  - Drive ≥20 entries through in total to exercise pointer wrap across index 7 → 0.
- Simultaneous push/pop at count=6: one valid lane in, one popped out.
  - count stays 6, in_ready stays 1, data order is preserved.
- Flush with count=5 and both lanes valid in the same cycle.
  - wb_en=0 that cycle; next cycle count=0 and in_ready=1.
  - overflow_err is unchanged.
- Async reset while count=4: assert reset=0 between clock edges.
  - count, wb_en and overflow_err go to 0 immediately, without waiting for a clock edge.
  - After release, a new push behaves as in the single-result scenario.
